// File: rtl/sudoku_ctrl.sv
// Sudoku solver controller: loads 81 cells into the engine grid, supervises solver
// passes, then streams the solved grid out three cells per beat.
module sudoku_ctrl #(
  parameter int MAX_IDLE_PASSES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cell_valid,
  input  logic [3:0]  cell_data,
  output logic        cell_ready,
  output logic        gw_en,
  output logic [6:0]  gw_addr,
  output logic [3:0]  gw_data,
  output logic [6:0]  gr_addr,
  input  logic [3:0]  gr_data,
  output logic        eng_start,
  input  logic        eng_pass_end,
  input  logic        eng_progress,
  input  logic        eng_done,
  output logic        out_valid,
  output logic [11:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        solved,
  output logic        stuck,
  output logic        err
);

  localparam int IW = (MAX_IDLE_PASSES < 1) ? 1 : $clog2(MAX_IDLE_PASSES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_SOLVE = 3'd3,
    S_READ  = 3'd4,
    S_SEND  = 3'd5,
    S_FAIL  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      load_cnt_q, load_cnt_d;
  logic [6:0]      base_q, base_d;
  logic [1:0]      rd_cnt_q, rd_cnt_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [11:0]     out_data_q, out_data_d;
  logic            solved_q, solved_d;
  logic            stuck_q, stuck_d;
  logic            err_q, err_d;

  logic            accept;
  logic            bad_cell;
  logic [1:0]      rd_sel;
  logic [IW-1:0]   idle_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      base_q     <= '0;
      rd_cnt_q   <= '0;
      idle_cnt_q <= '0;
      out_data_q <= '0;
      solved_q   <= 1'b0;
      stuck_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      base_q     <= base_d;
      rd_cnt_q   <= rd_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      out_data_q <= out_data_d;
      solved_q   <= solved_d;
      stuck_q    <= stuck_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    base_d     = base_q;
    rd_cnt_d   = rd_cnt_q;
    idle_cnt_d = idle_cnt_q;
    out_data_d = out_data_q;
    solved_d   = solved_q;
    stuck_d    = stuck_q;
    err_d      = err_q;

    cell_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    accept     = cell_valid && cell_ready && !reset;
    bad_cell   = cell_data > 4'd9;
    gw_en      = 1'b0;
    gw_addr    = load_cnt_q;
    gw_data    = 4'd0;
    eng_start  = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    idle_inc   = idle_cnt_q + IW'(1);
    // The fourth READ cycle only captures; keep the address on the last cell.
    rd_sel     = (rd_cnt_q == 2'd3) ? 2'd2 : rd_cnt_q;
    gr_addr    = base_q + {5'd0, rd_sel};

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          solved_d = 1'b0;
          if (bad_cell) begin
            err_d   = 1'b1;
            state_d = S_FAIL;
          end else begin
            gw_en      = 1'b1;
            gw_data    = cell_data;
            load_cnt_d = 7'd1;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        busy = 1'b1;
        if (accept) begin
          if (bad_cell) begin
            err_d   = 1'b1;
            state_d = S_FAIL;
          end else begin
            gw_en   = 1'b1;
            gw_data = cell_data;
            if (load_cnt_q == 7'd80) begin
              load_cnt_d = 7'd0;
              state_d    = S_START;
            end else begin
              load_cnt_d = load_cnt_q + 7'd1;
            end
          end
        end
      end
      S_START: begin
        busy       = 1'b1;
        eng_start  = 1'b1;
        idle_cnt_d = '0;
        state_d    = S_SOLVE;
      end
      S_SOLVE: begin
        busy = 1'b1;
        // Completion outranks a stalled pass reported in the same cycle.
        if (eng_done) begin
          base_d   = 7'd0;
          rd_cnt_d = 2'd0;
          state_d  = S_READ;
        end else if (eng_pass_end) begin
          if (eng_progress) begin
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_inc;
            if (idle_inc >= IW'(MAX_IDLE_PASSES)) begin
              stuck_d = 1'b1;
              state_d = S_FAIL;
            end
          end
        end
      end
      S_READ: begin
        busy     = 1'b1;
        rd_cnt_d = rd_cnt_q + 2'd1;
        if (rd_cnt_q != 2'd0) begin
          out_data_d = {out_data_q[7:0], gr_data};
        end
        if (rd_cnt_q == 2'd3) begin
          rd_cnt_d = 2'd0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (base_q == 7'd78) begin
            base_d   = 7'd0;
            solved_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            base_d  = base_q + 7'd3;
            state_d = S_READ;
          end
        end
      end
      S_FAIL: begin
      end
      default: begin
        state_d = S_FAIL;
      end
    endcase
  end

  assign out_data = out_data_q;
  assign solved   = solved_q;
  assign stuck    = stuck_q;
  assign err      = err_q;

endmodule
